// File: rtl/bg_pkg.sv
// bg_pkg: background geometry, VGA timing constants, query FSM states and fetch types
package bg_pkg;
    localparam int BG_W     = 100;
    localparam int BG_H     = 180;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int V_ACTIVE = 480;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} q_state_t;
    typedef logic [14:0] addr_t;
    typedef logic [3:0]  idx_t;
endpackage

// File: rtl/bg_tex_counter.sv
// bg_tex_counter: scrolled texel column/row tracking with an incrementally maintained row base
module bg_tex_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic [6:0]  act_x,
    input  logic [7:0]  act_y,
    output logic [14:0] disp_addr
);
    import bg_pkg::*;
    logic [6:0] tex_x_q, tex_x_d, tex_x_cur;
    logic [7:0] tex_y_q, tex_y_d;
    addr_t      row_base_q, row_base_d;
    logic       row_wrap;
    always_comb begin
        tex_x_cur  = (draw_x == 10'd0) ? act_x : tex_x_q;
        tex_x_d    = (tex_x_cur == 7'(BG_W - 1)) ? 7'd0 : tex_x_cur + 7'd1;
        row_wrap   = (tex_y_q == 8'(BG_H - 1));
        tex_y_d    = tex_y_q;
        row_base_d = row_base_q;
        if (draw_x == 10'(H_TOTAL - 1)) begin
            if (draw_y == 10'(V_TOTAL - 1)) begin
                tex_y_d    = act_y;
                row_base_d = 15'(act_y) * 15'(BG_W);
            end else if (draw_y < 10'(V_ACTIVE - 1)) begin
                tex_y_d    = row_wrap ? 8'd0 : tex_y_q + 8'd1;
                row_base_d = row_wrap ? 15'd0 : row_base_q + 15'(BG_W);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tex_x_q    <= '0;
            tex_y_q    <= '0;
            row_base_q <= '0;
        end else begin
            tex_x_q    <= tex_x_d;
            tex_y_q    <= tex_y_d;
            row_base_q <= row_base_d;
        end
    end
    assign disp_addr = row_base_q + 15'(tex_x_cur);
endmodule

// File: rtl/bg_scroll_sched.sv
// bg_scroll_sched: owns the bg_rom port, scrolled display fetch in active video, texel queries in blanking
module bg_scroll_sched (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank,
    input  logic        scroll_we,
    input  logic [6:0]  scroll_x_in,
    input  logic [7:0]  scroll_y_in,
    input  logic        q_req,
    input  logic [6:0]  q_x,
    input  logic [7:0]  q_y,
    output logic        q_ack,
    output logic        q_valid,
    output logic [3:0]  q_data,
    output logic        q_err,
    output logic [14:0] rom_addr,
    input  logic [3:0]  rom_q,
    output logic [3:0]  disp_idx,
    output logic        frame_start
);
    import bg_pkg::*;
    q_state_t   state_q, state_d;
    logic [6:0] pend_x_q, pend_x_d, act_x_q, act_x_d, qx_q, qx_d;
    logic [7:0] pend_y_q, pend_y_d, act_y_q, act_y_d, qy_q, qy_d;
    idx_t       lat_data_q, lat_data_d, q_data_q, q_data_d, disp_idx_q, disp_idx_d;
    logic       lat_err_q, lat_err_d, q_err_q, q_err_d, q_ack_q, q_ack_d, q_valid_q, q_valid_d;
    logic       frame_start_q, apply, q_oor;
    addr_t      disp_addr, q_addr;
    bg_tex_counter u_tex (
        .clk       (vga_clk),
        .reset     (reset),
        .draw_x    (DrawX),
        .draw_y    (DrawY),
        .act_x     (act_x_q),
        .act_y     (act_y_q),
        .disp_addr (disp_addr)
    );
    always_comb begin
        apply      = (DrawY == 10'(V_ACTIVE)) && (DrawX == 10'd0);
        q_oor      = (q_x >= 7'(BG_W)) || (q_y >= 8'(BG_H));
        q_addr     = 15'(qy_q) * 15'(BG_W) + 15'(qx_q);
        pend_x_d   = !scroll_we ? pend_x_q : (scroll_x_in >= 7'(BG_W)) ? scroll_x_in - 7'(BG_W) : scroll_x_in;
        pend_y_d   = !scroll_we ? pend_y_q : (scroll_y_in >= 8'(BG_H)) ? scroll_y_in - 8'(BG_H) : scroll_y_in;
        act_x_d    = apply ? pend_x_q : act_x_q;
        act_y_d    = apply ? pend_y_q : act_y_q;
        disp_idx_d = blank ? rom_q : 4'd0;
        state_d    = state_q;
        qx_d       = qx_q;
        qy_d       = qy_q;
        lat_data_d = lat_data_q;
        lat_err_d  = lat_err_q;
        q_ack_d    = 1'b0;
        q_valid_d  = 1'b0;
        q_data_d   = q_data_q;
        q_err_d    = q_err_q;
        case (state_q)
            IDLE: if (q_req) begin
                qx_d       = q_x;
                qy_d       = q_y;
                q_ack_d    = 1'b1;
                lat_err_d  = q_oor;
                lat_data_d = 4'd0;
                state_d    = q_oor ? RESP : ISSUE;
            end
            ISSUE: if (!blank) begin
                lat_data_d = rom_q;
                state_d    = RESP;
            end
            RESP: begin
                q_valid_d = 1'b1;
                q_data_d  = lat_data_q;
                q_err_d   = lat_err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rom_addr = (!blank && state_q == ISSUE) ? q_addr : disp_addr;
    end
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pend_x_q      <= '0;
            pend_y_q      <= '0;
            act_x_q       <= '0;
            act_y_q       <= '0;
            qx_q          <= '0;
            qy_q          <= '0;
            lat_data_q    <= '0;
            lat_err_q     <= 1'b0;
            q_ack_q       <= 1'b0;
            q_valid_q     <= 1'b0;
            q_data_q      <= '0;
            q_err_q       <= 1'b0;
            disp_idx_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_x_q      <= pend_x_d;
            pend_y_q      <= pend_y_d;
            act_x_q       <= act_x_d;
            act_y_q       <= act_y_d;
            qx_q          <= qx_d;
            qy_q          <= qy_d;
            lat_data_q    <= lat_data_d;
            lat_err_q     <= lat_err_d;
            q_ack_q       <= q_ack_d;
            q_valid_q     <= q_valid_d;
            q_data_q      <= q_data_d;
            q_err_q       <= q_err_d;
            disp_idx_q    <= disp_idx_d;
            frame_start_q <= apply;
        end
    end
    assign q_ack       = q_ack_q;
    assign q_valid     = q_valid_q;
    assign q_data      = q_data_q;
    assign q_err       = q_err_q;
    assign disp_idx    = disp_idx_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_bg_scroll_sched.sv
// tb_bg_scroll_sched: directed plus randomized checks of display fetch, scroll apply and texel queries
module tb_bg_scroll_sched;
    logic        vga_clk = 1'b0, reset = 1'b1;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        blank = 1'b0, scroll_we = 1'b0, q_req = 1'b0;
    logic [6:0]  scroll_x_in = '0, q_x = '0;
    logic [7:0]  scroll_y_in = '0, q_y = '0;
    logic        q_ack, q_valid, q_err, frame_start;
    logic [3:0]  q_data, disp_idx;
    logic [3:0]  rom_q = '0;
    logic [14:0] rom_addr;
    logic [3:0]  rom [18000];
    int checks = 0, errors = 0;
    int pend_x = 0, pend_y = 0, act_x = 0, act_y = 0, frame_y = 0;

    bg_scroll_sched dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .scroll_we   (scroll_we),
        .scroll_x_in (scroll_x_in),
        .scroll_y_in (scroll_y_in),
        .q_req       (q_req),
        .q_x         (q_x),
        .q_y         (q_y),
        .q_ack       (q_ack),
        .q_valid     (q_valid),
        .q_data      (q_data),
        .q_err       (q_err),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .disp_idx    (disp_idx),
        .frame_start (frame_start)
    );

    always #5 vga_clk = ~vga_clk;
    always @(negedge vga_clk) rom_q <= (int'(rom_addr) < 18000) ? rom[rom_addr] : 4'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // one pixel cycle; exp is the model's display address or -1 when not modelled
    task automatic pixel(input int x, input int y, input logic b, input int exp);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        #1;
        if (exp >= 0) check("disp_addr", rom_addr, exp);
        tick();
        scroll_we = 1'b0;
        if (exp >= 0 || !b) check("disp_idx", disp_idx, b ? int'(rom[exp]) : 0);
        check("frame_start", frame_start, (x == 0 && y == 480));
    endtask

    task automatic run_frame(input int wr_line, input int wx, input int wy, input int line0_len);
        for (int y = 0; y < 525; y++) begin
            int n;
            n = (y == 0) ? line0_len : (y < 3 || y == 479) ? 4 : 1;
            if (y >= 480) n = 1;
            if (y == wr_line) begin
                scroll_we   = 1'b1;
                scroll_x_in = 7'(wx);
                scroll_y_in = 8'(wy);
            end
            for (int x = 0; x < n; x++)
                pixel(x, y, y < 480, y < 480 ? ((frame_y + y) % 180) * 100 + (act_x + x) % 100 : -1);
            if (y == 480) begin
                act_x = pend_x;
                act_y = pend_y;
            end
            if (y == wr_line) begin
                pend_x = wx % 100;
                pend_y = wy % 180;
            end
            pixel(799, y, 1'b0, -1);
            if (y == 524) frame_y = act_y;
        end
    endtask

    // display sits at DrawX=0, DrawY=0 with zero scroll, so its address is 0 throughout
    task automatic query(input int x, input int y, input int nwait);
        int addr, k;
        bit oor;
        oor  = (x >= 100) || (y >= 180);
        addr = y * 100 + x;
        DrawX = '0;
        DrawY = '0;
        q_req = 1'b1;
        q_x   = 7'(x);
        q_y   = 8'(y);
        blank = 1'b1;
        tick();
        check("q_ack", q_ack, 1);
        check("q_valid_at_ack", q_valid, 0);
        if (oor) begin
            q_req = 1'b0;
            blank = 1'b0;
            #1;
            check("oor_port", rom_addr, 0);
            tick();
            check("oor_valid", q_valid, 1);
            check("oor_err", q_err, 1);
            check("oor_data", q_data, 0);
        end else begin
            for (int i = 0; i < nwait; i++) begin
                q_req = 1'b1;
                q_x   = 7'($urandom);
                blank = 1'b1;
                #1;
                check("wait_port", rom_addr, 0);
                tick();
                check("wait_ack", q_ack, 0);
                check("wait_valid", q_valid, 0);
            end
            q_req = 1'b0;
            blank = 1'b0;
            #1;
            check("issue_port", rom_addr, addr);
            k = 0;
            do begin
                tick();
                k++;
            end while (q_valid !== 1'b1 && k < 4);
            check("valid_seen", q_valid, 1);
            check("q_data", q_data, rom[addr]);
            check("q_err", q_err, 0);
            if (nwait == 0) check("valid_gap_ge2", k >= 2, 1);
        end
        tick();
        check("valid_pulse_end", q_valid, 0);
        check("q_err_hold", q_err, oor);
        check("q_data_hold", q_data, oor ? 0 : int'(rom[addr]));
    endtask

    initial begin
        foreach (rom[i]) rom[i] = 4'($urandom);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_q_ack", q_ack, 0);
        check("rst_q_valid", q_valid, 0);
        check("rst_q_data", q_data, 0);
        check("rst_q_err", q_err, 0);
        check("rst_disp_idx", disp_idx, 0);
        check("rst_frame_start", frame_start, 0);
        #1;
        check("rst_rom_addr", rom_addr, 0);

        query(3, 2, 3);
        query(100, 0, 0);
        query(0, 180, 0);
        query(99, 179, 0);
        for (int i = 0; i < 8; i++)
            query($urandom_range(0, 127), $urandom_range(0, 199), $urandom_range(0, 5));

        q_req = 1'b1;
        q_x   = 7'd3;
        q_y   = 8'd2;
        blank = 1'b1;
        tick();
        check("pre_rst_ack", q_ack, 1);
        q_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_issue_data", q_data, 0);
        for (int i = 0; i < 4; i++) begin
            blank = 1'b0;
            #1;
            check("rst_issue_port", rom_addr, 0);
            tick();
            check("rst_issue_no_valid", q_valid, 0);
        end
        query(3, 2, 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_frame(100, 127, 255, 110);
        run_frame(480, 55, 179, 6);
        run_frame(-1, 0, 0, 6);
        run_frame(-1, 0, 0, 6);
        for (int f = 0; f < 2; f++)
            run_frame($urandom_range(0, 524), $urandom_range(0, 127), $urandom_range(0, 255), $urandom_range(1, 120));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
